// File: rtl/multicycle_control_pkg.sv
// Shared constants and types for the multi-cycle RV32I control FSM.
// Holds the opcodes, state encodings, ALU op codes, mux selects and the strobe bundle.
package multicycle_control_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE   = 4'd6;
  localparam logic [3:0] S_ALU_WB    = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_TRAP      = 4'd9;

  localparam logic [2:0] ALUOP_ADD = 3'b000;
  localparam logic [2:0] ALUOP_SUB = 3'b001;
  localparam logic [2:0] ALUOP_R   = 3'b010;
  localparam logic [2:0] ALUOP_I   = 3'b011;

  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_REG   = 2'd1;
  localparam logic [1:0] SRC_A_OLDPC = 2'd2;
  localparam logic [1:0] SRC_B_REG   = 2'd0;
  localparam logic [1:0] SRC_B_FOUR  = 2'd1;
  localparam logic [1:0] SRC_B_IMM   = 2'd2;

  typedef enum logic [2:0] {
    CLS_LOAD,
    CLS_STORE,
    CLS_RTYPE,
    CLS_ITYPE,
    CLS_BRANCH,
    CLS_ILLEGAL
  } op_class_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       illegal;
    logic       instr_done;
  } ctrl_t;

  function automatic op_class_t classify(input logic [6:0] opcode, input logic imm_alu_en);
    op_class_t cls;
    case (opcode)
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      OP_RTYPE:  cls = CLS_RTYPE;
      OP_ITYPE:  cls = imm_alu_en ? CLS_ITYPE : CLS_ILLEGAL;
      OP_BRANCH: cls = CLS_BRANCH;
      default:   cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control <-> datapath bundle: instruction/flag inputs, memory handshake and datapath strobes.
// pc_load folds the conditional branch enable with the zero flag for the PC register.
interface multicycle_control_if;

  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       pc_source;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       pc_load;

  assign pc_load = pc_write | (pc_write_cond & zero);

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
           ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
           ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_load
  );

endinterface

// File: rtl/multicycle_control_decode.sv
// Combinational strobe map from the current state, opcode class and memory handshake.
// Every strobe is forced low while reset is asserted so an in-flight write is dropped at once.
module control_decode
  import multicycle_control_pkg::*;
(
  input  logic       reset,
  input  logic [3:0] state,
  input  op_class_t  op_class,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          ctrl.iord      = 1'b0;
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_a = SRC_A_PC;
          ctrl.alu_src_b = SRC_B_FOUR;
          ctrl.alu_op    = ALUOP_ADD;
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;
        end
        S_DECODE: begin
          ctrl.alu_src_a = SRC_A_OLDPC;
          ctrl.alu_src_b = SRC_B_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEM_ADDR: begin
          ctrl.alu_src_a = SRC_A_REG;
          ctrl.alu_src_b = SRC_B_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEM_READ: begin
          ctrl.iord     = 1'b1;
          ctrl.mem_read = 1'b1;
        end
        S_MEM_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          ctrl.iord       = 1'b1;
          ctrl.mem_write  = 1'b1;
          ctrl.instr_done = mem_ready;
        end
        S_EXECUTE: begin
          ctrl.alu_src_a = SRC_A_REG;
          if (op_class == CLS_ITYPE) begin
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALUOP_I;
          end else begin
            ctrl.alu_src_b = SRC_B_REG;
            ctrl.alu_op    = ALUOP_R;
          end
        end
        S_ALU_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b0;
          ctrl.instr_done = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a     = SRC_A_REG;
          ctrl.alu_src_b     = SRC_B_REG;
          ctrl.alu_op        = ALUOP_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = 1'b1;
          ctrl.instr_done    = 1'b1;
        end
        S_TRAP: begin
          ctrl.illegal = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: state register, is_load capture and next-state logic.
// Output strobes come from control_decode; TRAP is left only through reset, so illegal is sticky.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned STATE_W    = 4,
  parameter bit          IMM_ALU_EN = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_control_if.master bus,
  output logic                illegal,
  output logic                instr_done,
  output logic [STATE_W-1:0]  state_dbg
);

  logic [3:0] state;
  logic [3:0] state_next;
  logic       is_load;
  op_class_t  op_class;
  ctrl_t      ctrl;

  assign op_class = classify(bus.opcode, IMM_ALU_EN);

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:     state_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op_class)
          CLS_LOAD, CLS_STORE: state_next = S_MEM_ADDR;
          CLS_RTYPE, CLS_ITYPE: state_next = S_EXECUTE;
          CLS_BRANCH:          state_next = S_BRANCH;
          default:             state_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR:  state_next = is_load ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_next = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_next = S_FETCH;
      S_MEM_WRITE: state_next = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   state_next = S_ALU_WB;
      S_ALU_WB:    state_next = S_FETCH;
      S_BRANCH:    state_next = S_FETCH;
      S_TRAP:      state_next = S_TRAP;
      default:     state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      is_load <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) is_load <= (op_class == CLS_LOAD);
    end
  end

  control_decode u_decode (
    .reset     (reset),
    .state     (state),
    .op_class  (op_class),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.iord          = ctrl.iord;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign illegal           = ctrl.illegal;
  assign instr_done        = ctrl.instr_done;
  assign state_dbg         = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state and strobe checks for every instruction path.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       illegal;
  logic       instr_done;
  logic [3:0] state_dbg;
  int         checks = 0;
  int         errors = 0;

  multicycle_control_if bus();

  multicycle_control #(.STATE_W(4), .IMM_ALU_EN(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .illegal    (illegal),
    .instr_done (instr_done),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  // bit order: pcw pcwc pcs iord mr mw irw m2r rw src_a[2] src_b[2] alu_op[3] illegal done
  function automatic logic [17:0] pk(input bit pcw, pcwc, pcs, io, mr, mw, irw, m2r, rw,
                                     input int sa, sb, aop, input bit ill, done);
    logic [1:0] a2;
    logic [1:0] b2;
    logic [2:0] o3;
    a2 = sa[1:0];
    b2 = sb[1:0];
    o3 = aop[2:0];
    return {pcw, pcwc, pcs, io, mr, mw, irw, m2r, rw, a2, b2, o3, ill, done};
  endfunction

  function automatic logic [17:0] strobes();
    return {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.iord, bus.mem_read,
            bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, illegal, instr_done};
  endfunction

  logic [17:0] V_ZERO, V_FETCH_GO, V_FETCH_WAIT, V_DECODE, V_MEM_ADDR, V_MEM_READ, V_MEM_WB;
  logic [17:0] V_MEM_WRITE_GO, V_MEM_WRITE_WAIT, V_EXEC_R, V_EXEC_I, V_ALU_WB, V_BRANCH, V_TRAP;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode = 7'b0110011;
    bus.zero = 1'b0;
    repeat (3) tick();
    #2;
    checks++;
    if (state_dbg !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_dbg); end
    checks++;
    if (strobes() !== V_ZERO) begin errors++; $display("FAIL reset_strobes got %h want %h", strobes(), V_ZERO); end
    tick();
  endtask

  task automatic test_rtype();
    logic [3:0]  st  [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    logic        rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [17:0] vec [5];
    int          done_cnt = 0;
    vec = '{V_FETCH_GO, V_DECODE, V_EXEC_R, V_ALU_WB, V_FETCH_WAIT};
    reset = 1'b0;
    bus.opcode = 7'b0110011;
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = rdy[i];
      #2;
      if (i < 4 && instr_done === 1'b1) done_cnt++;
      checks++;
      if (state_dbg !== st[i]) begin errors++; $display("FAIL rtype_state[%0d] got %0d want %0d", i, state_dbg, st[i]); end
      checks++;
      if (strobes() !== vec[i]) begin errors++; $display("FAIL rtype_strobes[%0d] got %h want %h", i, strobes(), vec[i]); end
      tick();
    end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL rtype_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_itype();
    logic [3:0]  st  [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    logic        rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [17:0] vec [5];
    vec = '{V_FETCH_GO, V_DECODE, V_EXEC_I, V_ALU_WB, V_FETCH_WAIT};
    bus.opcode = 7'b0010011;
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = rdy[i];
      #2;
      checks++;
      if (state_dbg !== st[i]) begin errors++; $display("FAIL itype_state[%0d] got %0d want %0d", i, state_dbg, st[i]); end
      checks++;
      if (strobes() !== vec[i]) begin errors++; $display("FAIL itype_strobes[%0d] got %h want %h", i, strobes(), vec[i]); end
      tick();
    end
  endtask

  task automatic test_load_stall();
    logic [3:0]  st  [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    logic        rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [17:0] vec [8];
    vec = '{V_FETCH_GO, V_DECODE, V_MEM_ADDR, V_MEM_READ, V_MEM_READ, V_MEM_READ, V_MEM_WB, V_FETCH_WAIT};
    bus.opcode = 7'b0000011;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = rdy[i];
      #2;
      checks++;
      if (state_dbg !== st[i]) begin errors++; $display("FAIL load_state[%0d] got %0d want %0d", i, state_dbg, st[i]); end
      checks++;
      if (strobes() !== vec[i]) begin errors++; $display("FAIL load_strobes[%0d] got %h want %h", i, strobes(), vec[i]); end
      tick();
    end
  endtask

  task automatic test_store();
    logic [3:0]  st  [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    logic        rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [17:0] vec [5];
    int          mw_cnt = 0;
    int          rw_cnt = 0;
    vec = '{V_FETCH_GO, V_DECODE, V_MEM_ADDR, V_MEM_WRITE_GO, V_FETCH_WAIT};
    bus.opcode = 7'b0100011;
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = rdy[i];
      #2;
      if (bus.mem_write === 1'b1) mw_cnt++;
      if (bus.reg_write === 1'b1) rw_cnt++;
      checks++;
      if (state_dbg !== st[i]) begin errors++; $display("FAIL store_state[%0d] got %0d want %0d", i, state_dbg, st[i]); end
      checks++;
      if (strobes() !== vec[i]) begin errors++; $display("FAIL store_strobes[%0d] got %h want %h", i, strobes(), vec[i]); end
      tick();
    end
    checks++;
    if (mw_cnt !== 1 || rw_cnt !== 0) begin
      errors++; $display("FAIL store_counts mem_write=%0d reg_write=%0d want 1 and 0", mw_cnt, rw_cnt);
    end
  endtask

  task automatic test_branch(input logic z);
    logic [3:0]  st  [4] = '{4'd0, 4'd1, 4'd8, 4'd0};
    logic        rdy [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [17:0] vec [4];
    vec = '{V_FETCH_GO, V_DECODE, V_BRANCH, V_FETCH_WAIT};
    bus.opcode = 7'b1100011;
    bus.zero = z;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = rdy[i];
      #2;
      checks++;
      if (state_dbg !== st[i]) begin errors++; $display("FAIL branch_z%0d_state[%0d] got %0d want %0d", z, i, state_dbg, st[i]); end
      checks++;
      if (strobes() !== vec[i]) begin errors++; $display("FAIL branch_z%0d_strobes[%0d] got %h want %h", z, i, strobes(), vec[i]); end
      if (i == 2) begin
        checks++;
        if (bus.pc_load !== z) begin errors++; $display("FAIL branch_pc_load got %b want %b", bus.pc_load, z); end
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    bus.opcode = 7'b1111111;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      bus.mem_ready = i[0];
      #2;
      checks++;
      if (state_dbg !== 4'd9 || strobes() !== V_TRAP) begin
        errors++; $display("FAIL trap_hold[%0d] state %0d strobes %h want 9 %h", i, state_dbg, strobes(), V_TRAP);
      end
      tick();
    end
    reset = 1'b1;
    tick();
    #2;
    checks++;
    if (state_dbg !== 4'd0 || illegal !== 1'b0) begin
      errors++; $display("FAIL trap_reset state %0d illegal %b want 0 0", state_dbg, illegal);
    end
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    #2;
    checks++;
    if (strobes() !== V_FETCH_WAIT) begin errors++; $display("FAIL trap_release got %h want %h", strobes(), V_FETCH_WAIT); end
    tick();
  endtask

  task automatic test_reset_mid_write();
    bus.opcode = 7'b0100011;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    tick();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++;
      if (state_dbg !== 4'd5 || strobes() !== V_MEM_WRITE_WAIT) begin
        errors++; $display("FAIL midwr_pending[%0d] state %0d strobes %h want 5 %h", i, state_dbg, strobes(), V_MEM_WRITE_WAIT);
      end
      tick();
    end
    reset = 1'b1;
    tick();
    #2;
    checks++;
    if (state_dbg !== 4'd0 || bus.mem_write !== 1'b0 || strobes() !== V_ZERO) begin
      errors++; $display("FAIL midwr_reset state %0d strobes %h want 0 %h", state_dbg, strobes(), V_ZERO);
    end
    reset = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++;
      if (state_dbg !== 4'd0 || strobes() !== V_FETCH_WAIT) begin
        errors++; $display("FAIL midwr_stall[%0d] state %0d strobes %h want 0 %h", i, state_dbg, strobes(), V_FETCH_WAIT);
      end
      tick();
    end
    bus.mem_ready = 1'b1;
    #2;
    checks++;
    if (strobes() !== V_FETCH_GO) begin errors++; $display("FAIL midwr_fetch_go got %h want %h", strobes(), V_FETCH_GO); end
    tick();
    #2;
    checks++;
    if (state_dbg !== 4'd1) begin errors++; $display("FAIL midwr_decode got %0d want 1", state_dbg); end
  endtask

  initial begin
    V_ZERO           = '0;
    V_FETCH_GO       = pk(1,0,0,0,1,0,1,0,0, 0,1,0, 0,0);
    V_FETCH_WAIT     = pk(0,0,0,0,1,0,0,0,0, 0,1,0, 0,0);
    V_DECODE         = pk(0,0,0,0,0,0,0,0,0, 2,2,0, 0,0);
    V_MEM_ADDR       = pk(0,0,0,0,0,0,0,0,0, 1,2,0, 0,0);
    V_MEM_READ       = pk(0,0,0,1,1,0,0,0,0, 0,0,0, 0,0);
    V_MEM_WB         = pk(0,0,0,0,0,0,0,1,1, 0,0,0, 0,1);
    V_MEM_WRITE_GO   = pk(0,0,0,1,0,1,0,0,0, 0,0,0, 0,1);
    V_MEM_WRITE_WAIT = pk(0,0,0,1,0,1,0,0,0, 0,0,0, 0,0);
    V_EXEC_R         = pk(0,0,0,0,0,0,0,0,0, 1,0,2, 0,0);
    V_EXEC_I         = pk(0,0,0,0,0,0,0,0,0, 1,2,3, 0,0);
    V_ALU_WB         = pk(0,0,0,0,0,0,0,0,1, 0,0,0, 0,1);
    V_BRANCH         = pk(0,1,1,0,0,0,0,0,0, 1,0,1, 0,1);
    V_TRAP           = pk(0,0,0,0,0,0,0,0,0, 0,0,0, 1,0);

    test_reset();
    test_rtype();
    test_itype();
    test_load_stall();
    test_store();
    test_branch(1'b1);
    test_branch(1'b0);
    test_illegal();
    test_reset_mid_write();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
